// File: rtl/dac_spi_tx_if.sv
// Sample handshake between the summing stage and the LTC2624 transmitter.
// The source (master) drives the sample and start; the transmitter (slave)
// answers with ready and a done pulse per completed frame.
interface dac_spi_tx_if;
    logic [11:0] data_in;
    logic        start;
    logic        ready;
    logic        done;

    modport master (output data_in, output start, input ready, input done);
    modport slave  (input data_in, input start, output ready, output done);
endinterface

// File: rtl/dac_spi_tx.sv
// LTC2624 serial transmitter: frames one 12-bit offset-binary sample into a
// 32-bit write-and-update word and shifts it out MSB first on dac_sck rising
// edges. Optional feature macro: DAC_CLR_EN (post-reset dac_clr_n pulse and
// CLR_WAIT state before the first frame may be accepted).
module dac_spi_tx #(
    parameter int         CLK_DIV  = 2,       // SCK half-period in clk cycles, 1..255
    parameter logic [3:0] DAC_CMD  = 4'b0011, // write and update
    parameter logic [3:0] DAC_ADDR = 4'b1111, // all channels
    parameter int         CS_GAP   = 4        // cs_n high time between frames, >= 1
) (
    input  logic         clk,
    input  logic         reset,
    dac_spi_tx_if.slave  bus,
    output logic         dac_mosi,
    output logic         dac_sck,
    output logic         dac_cs_n,
    output logic         dac_clr_n
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam int         GW       = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

`ifdef DAC_CLR_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, CLR_WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_div,   w_div_nxt;   // clk cycles within the current SCK half-period
    logic [5:0]    r_tog,   w_tog_nxt;   // SCK toggles so far in this frame (64 per frame)
    logic [31:0]   r_sr,    w_sr_nxt;    // frame shift register, bit 31 is on the wire
    logic [GW-1:0] r_gap,   w_gap_nxt;
    logic          r_sck,   w_sck_nxt;
    logic          r_mosi,  w_mosi_nxt;
    logic          r_cs_n,  w_cs_n_nxt;
    logic          r_done,  w_done_nxt;
    logic [31:0]   w_frame;
`ifdef DAC_CLR_EN
    logic          r_clr_n,   w_clr_n_nxt;
    logic [3:0]    r_clr_cnt, w_clr_cnt_nxt;
    logic [3:0]    w_clr_cnt_inc;
`endif

    assign w_frame = {8'h00, DAC_CMD, DAC_ADDR, bus.data_in, 4'h0};

    // State and output registers; all pins are registered so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef DAC_CLR_EN
            r_state   <= CLR_WAIT;
            r_clr_n   <= 1'b1;
            r_clr_cnt <= 4'd0;
`else
            r_state   <= IDLE;
`endif
            r_div     <= 8'd0;
            r_tog     <= 6'd0;
            r_sr      <= 32'd0;
            r_gap     <= '0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_tog     <= w_tog_nxt;
            r_sr      <= w_sr_nxt;
            r_gap     <= w_gap_nxt;
            r_sck     <= w_sck_nxt;
            r_mosi    <= w_mosi_nxt;
            r_cs_n    <= w_cs_n_nxt;
            r_done    <= w_done_nxt;
`ifdef DAC_CLR_EN
            r_clr_n   <= w_clr_n_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
`endif
        end
    end

    // Next-state logic: accept a sample, pace SCK, shift on falling edges,
    // and close the frame on the 64th toggle so cs_n is low 64*CLK_DIV cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_tog_nxt   = r_tog;
        w_sr_nxt    = r_sr;
        w_gap_nxt   = r_gap;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_cs_n_nxt  = r_cs_n;
        w_done_nxt  = 1'b0;
`ifdef DAC_CLR_EN
        w_clr_n_nxt   = r_clr_n;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_cnt_inc = r_clr_cnt + 4'd1;
`endif
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_sr_nxt    = w_frame;
                    w_mosi_nxt  = w_frame[31];
                    w_cs_n_nxt  = 1'b0;
                    w_sck_nxt   = 1'b0;
                    w_div_nxt   = 8'd0;
                    w_tog_nxt   = 6'd0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt = 8'd0;
                    w_tog_nxt = r_tog + 6'd1;
                    if (r_sck) begin
                        w_sck_nxt = 1'b0;
                        if (r_tog == 6'd63) begin
                            // last falling edge: release the DAC, which latches the word
                            w_cs_n_nxt  = 1'b1;
                            w_done_nxt  = 1'b1;
                            w_mosi_nxt  = 1'b0;
                            w_gap_nxt   = '0;
                            w_state_nxt = GAP;
                        end else begin
                            w_sr_nxt   = {r_sr[30:0], 1'b0};
                            w_mosi_nxt = r_sr[30];
                        end
                    end else begin
                        w_sck_nxt = 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
            GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_gap_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
`ifdef DAC_CLR_EN
            CLR_WAIT: begin
                // cycles 1..4 after reset: clr_n low; cycles 5..8: high; then IDLE
                w_clr_cnt_nxt = w_clr_cnt_inc;
                w_clr_n_nxt   = (w_clr_cnt_inc > 4'd4);
                if (r_clr_cnt == 4'd8) begin
                    w_clr_cnt_nxt = 4'd0;
                    w_clr_n_nxt   = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.ready = (r_state == IDLE);
    assign bus.done  = r_done;
    assign dac_mosi  = r_mosi;
    assign dac_sck   = r_sck;
    assign dac_cs_n  = r_cs_n;
`ifdef DAC_CLR_EN
    assign dac_clr_n = r_clr_n;
`else
    assign dac_clr_n = 1'b1;
`endif

endmodule
